// File: rtl/axis_sample_source_pkg.sv
// Shared definitions for the axis_sample_source test-sample generator:
// waveform mode codes, controller state encoding and the noise LFSR constants.
package axis_sample_source_pkg;

  localparam logic [1:0] MODE_IMPULSE = 2'd0;
  localparam logic [1:0] MODE_RAMP    = 2'd1;
  localparam logic [1:0] MODE_SQUARE  = 2'd2;
  localparam logic [1:0] MODE_NOISE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // One step of the right-shifting Galois LFSR: the bit shifted out selects the toggle mask.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/axis_sample_source_lfsr16.sv
// lfsr16: 16-bit Galois noise generator for axis_sample_source.
// Only compiled when AXIS_SRC_LFSR_EN is defined; the default build has no LFSR.
`ifdef AXIS_SRC_LFSR_EN
module lfsr16
  import axis_sample_source_pkg::*;
(
  input  logic        axi_clk,
  input  logic        axi_reset_n,
  input  logic        enable,
  input  logic        reseed,
  output logic [15:0] state
);

  // Reseed wins over advance so a new run always starts from the seed.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state <= LFSR_SEED;
    end else if (reseed) begin
      state <= LFSR_SEED;
    end else if (enable) begin
      state <= lfsr_step(state);
    end
  end

endmodule
`endif

// File: rtl/axis_sample_source.sv
// axis_sample_source: AXI4-Stream master producing framed impulse, ramp,
// square or noise samples with full valid/ready backpressure.
// Build option AXIS_SRC_LFSR_EN: compiles in noise mode and the lfsr16
// generator; without it mode 3 emits zero samples with normal framing.
module axis_sample_source
  import axis_sample_source_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_W      = 10
) (
  input  logic                         axi_clk,
  input  logic                         axi_reset_n,
  input  logic                         start,
  input  logic                         stop,
  input  logic [1:0]                   mode,
  input  logic [LEN_W-1:0]             frame_len,
  input  logic signed [DATA_WIDTH-1:0] amplitude,
  input  logic signed [DATA_WIDTH-1:0] step,
  output logic                         m_axis_valid,
  output logic signed [DATA_WIDTH-1:0] m_axis_data,
  output logic                         m_axis_last,
  input  logic                         m_axis_ready,
  output logic                         busy,
  output logic [15:0]                  frame_count
);

  state_t                       state;
  logic [1:0]                   mode_q;
  logic [LEN_W-1:0]             len_q;
  logic [LEN_W-1:0]             idx_q;
  logic signed [DATA_WIDTH-1:0] amp_q;
  logic signed [DATA_WIDTH-1:0] step_q;
  logic signed [DATA_WIDTH-1:0] acc_q;

  logic                         hs;
  logic                         last_hs;
  logic                         start_accept;
  logic [LEN_W-1:0]             len_in_eff;
  logic [LEN_W-1:0]             idx_nxt;
  logic signed [DATA_WIDTH-1:0] acc_nxt;
  logic [15:0]                  rnd_first;
  logic [15:0]                  rnd_nxt;

  // Sample value for frame position i; square negation wraps, so -(-max) stays -max.
  function automatic logic signed [DATA_WIDTH-1:0] sample_for(
    input logic [1:0]                   m,
    input logic [LEN_W-1:0]             i,
    input logic [LEN_W-1:0]             len,
    input logic signed [DATA_WIDTH-1:0] amp,
    input logic signed [DATA_WIDTH-1:0] acc,
    input logic [15:0]                  rnd
  );
    logic [LEN_W:0] half;
    half = ({1'b0, len} + (LEN_W+1)'(1)) >> 1;
    case (m)
      MODE_IMPULSE: sample_for = (i == '0) ? amp : '0;
      MODE_RAMP:    sample_for = acc;
      MODE_SQUARE:  sample_for = ({1'b0, i} < half) ? amp : -amp;
      default:      sample_for = DATA_WIDTH'(rnd);
    endcase
  endfunction

  assign hs           = m_axis_valid & m_axis_ready;
  assign last_hs      = hs & m_axis_last;
  assign start_accept = (state == ST_IDLE) & start;
  assign len_in_eff   = (frame_len == '0) ? LEN_W'(1) : frame_len;
  assign idx_nxt      = m_axis_last ? '0 : idx_q + LEN_W'(1);
  assign acc_nxt      = m_axis_last ? '0 : acc_q + step_q;

`ifdef AXIS_SRC_LFSR_EN
  logic [15:0] lfsr_state;

  lfsr16 u_lfsr16 (
    .axi_clk     (axi_clk),
    .axi_reset_n (axi_reset_n),
    .enable      (hs),
    .reseed      (start_accept),
    .state       (lfsr_state)
  );

  assign rnd_first = LFSR_SEED;
  assign rnd_nxt   = lfsr_step(lfsr_state);
`else
  assign rnd_first = '0;
  assign rnd_nxt   = '0;
`endif

  // Controller: latches config on start, presents the next sample on each handshake, ends on the final last beat.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state        <= ST_IDLE;
      mode_q       <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      amp_q        <= '0;
      step_q       <= '0;
      acc_q        <= '0;
      m_axis_valid <= 1'b0;
      m_axis_data  <= '0;
      m_axis_last  <= 1'b0;
      busy         <= 1'b0;
      frame_count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q       <= mode;
            len_q        <= len_in_eff;
            amp_q        <= amplitude;
            step_q       <= step;
            idx_q        <= '0;
            acc_q        <= '0;
            m_axis_valid <= 1'b1;
            m_axis_data  <= sample_for(mode, '0, len_in_eff, amplitude, '0, rnd_first);
            m_axis_last  <= (len_in_eff == LEN_W'(1));
            busy         <= 1'b1;
            state        <= ST_RUN;
          end
        end
        default: begin
          if (last_hs) begin
            frame_count <= frame_count + 16'd1;
          end
          if (last_hs && ((state == ST_DRAIN) || stop)) begin
            m_axis_valid <= 1'b0;
            m_axis_data  <= '0;
            m_axis_last  <= 1'b0;
            busy         <= 1'b0;
            state        <= ST_IDLE;
          end else begin
            if (hs) begin
              idx_q       <= idx_nxt;
              acc_q       <= acc_nxt;
              m_axis_data <= sample_for(mode_q, idx_nxt, len_q, amp_q, acc_nxt, rnd_nxt);
              m_axis_last <= (idx_nxt == len_q - LEN_W'(1));
            end
            if (stop) begin
              state <= ST_DRAIN;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_sample_source.sv
// Testbench for axis_sample_source: randomized stimulus against a frame-level
// reference model of the sample patterns.
module tb_axis_sample_source;

  localparam int DW = 16;
  localparam int LW = 10;

  logic                 axi_clk = 1'b0;
  logic                 axi_reset_n = 1'b0;
  logic                 start = 1'b0;
  logic                 stop = 1'b0;
  logic [1:0]           mode = '0;
  logic [LW-1:0]        frame_len = '0;
  logic signed [DW-1:0] amplitude = '0;
  logic signed [DW-1:0] step = '0;
  logic                 m_axis_ready = 1'b0;
  logic                 m_axis_valid;
  logic signed [DW-1:0] m_axis_data;
  logic                 m_axis_last;
  logic                 busy;
  logic [15:0]          frame_count;

  int errors = 0;
  int checks = 0;
  int exp_fc = 0;

  logic [DW-1:0] cap_d[$];
  logic          cap_l[$];
  logic [DW-1:0] exp_d[$];
  logic          exp_l[$];
  int            stall_changes;
  bit            first_valid;
  bit            timed_out;

  axis_sample_source #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
    .axi_clk      (axi_clk),
    .axi_reset_n  (axi_reset_n),
    .start        (start),
    .stop         (stop),
    .mode         (mode),
    .frame_len    (frame_len),
    .amplitude    (amplitude),
    .step         (step),
    .m_axis_valid (m_axis_valid),
    .m_axis_data  (m_axis_data),
    .m_axis_last  (m_axis_last),
    .m_axis_ready (m_axis_ready),
    .busy         (busy),
    .frame_count  (frame_count)
  );

  always #5 axi_clk = ~axi_clk;

  // Reference: beat k of a run is frame position k mod len; noise is the LFSR after k steps.
  function automatic void build_expected(input int md, input int len, input int amp,
                                         input int stp, input int n);
    int l;
    int i;
    int half;
    logic [15:0] lfsr;
    exp_d.delete();
    exp_l.delete();
    l = (len == 0) ? 1 : len;
    half = (l + 1) / 2;
    lfsr = 16'hACE1;
    for (int k = 0; k < n; k++) begin
      i = k % l;
      case (md)
        0:       exp_d.push_back((i == 0) ? 16'(amp) : 16'd0);
        1:       exp_d.push_back(16'(i * stp));
        2:       exp_d.push_back((i < half) ? 16'(amp) : 16'(-amp));
`ifdef AXIS_SRC_LFSR_EN
        default: exp_d.push_back(lfsr);
`else
        default: exp_d.push_back(16'd0);
`endif
      endcase
      exp_l.push_back(i == l - 1);
      lfsr = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    end
  endfunction

  // Called at posedge+1 with the DUT idle; leaves the DUT running, at posedge+1.
  task automatic do_start(input int md, input int len, input int amp, input int stp,
                          input bit with_stop);
    mode = 2'(md);
    frame_len = LW'(len);
    amplitude = DW'(amp);
    step = DW'(stp);
    m_axis_ready = 1'b1;
    start = 1'b1;
    stop = with_stop;
    @(posedge axi_clk);
    #1;
    start = 1'b0;
    stop = 1'b0;
  endtask

  // Drives ready (0: high, 1: 1010.., 2: random), pulses stop with beat stop_at, records beats until valid drops.
  task automatic collect(input int rmode, input int stop_at, input bit scramble, input int max_cycles);
    logic          pv, pr, pl;
    logic [DW-1:0] pd;
    bit            seen;
    int            nbeat;
    cap_d.delete();
    cap_l.delete();
    stall_changes = 0;
    timed_out = 1'b0;
    seen = 1'b0;
    nbeat = 0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge axi_clk);
      stop = 1'b0;
      start = 1'b0;
      if (c == 0) first_valid = m_axis_valid;
      if (pv && !pr && (m_axis_valid !== 1'b1 || m_axis_data !== pd || m_axis_last !== pl))
        stall_changes++;
      if (!m_axis_valid && seen) return;
      case (rmode)
        0:       m_axis_ready = 1'b1;
        1:       m_axis_ready = (c % 2 == 0);
        default: m_axis_ready = 1'($urandom_range(0, 1));
      endcase
      if (m_axis_valid && m_axis_ready) begin
        cap_d.push_back(m_axis_data);
        cap_l.push_back(m_axis_last);
        seen = 1'b1;
        if (nbeat == stop_at) stop = 1'b1;
        nbeat++;
      end
      pv = m_axis_valid; pr = m_axis_ready; pd = m_axis_data; pl = m_axis_last;
      if (scramble) begin
        start = 1'($urandom_range(0, 1));
        mode = 2'($urandom);
        frame_len = LW'($urandom);
        amplitude = DW'($urandom);
        step = DW'($urandom);
      end
    end
    timed_out = 1'b1;
    start = 1'b0;
    stop = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_axis_valid); end
    checks++; if (m_axis_data !== '0) begin errors++; $display("FAIL reset_data: got %0d want 0", m_axis_data); end
    checks++; if (m_axis_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", m_axis_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
  endtask

  task automatic test_impulse();
    do_start(0, 4, 100, 0, 1'b0);
    collect(0, 0, 1'b0, 60);
    build_expected(0, 4, 100, 0, 4);
    exp_fc += 1;
    checks++; if (timed_out) begin errors++; $display("FAIL impulse_timeout: got timeout want end of stream"); end
    checks++; if (first_valid !== 1'b1) begin errors++; $display("FAIL impulse_first_valid: got %b want 1", first_valid); end
    checks++; if (cap_d.size() != exp_d.size()) begin errors++; $display("FAIL impulse_beats: got %0d want %0d", cap_d.size(), exp_d.size()); end
    for (int k = 0; k < cap_d.size() && k < exp_d.size(); k++) begin
      checks++;
      if (cap_d[k] !== exp_d[k] || cap_l[k] !== exp_l[k]) begin
        errors++;
        $display("FAIL impulse_beat%0d: got data=%0d last=%b want data=%0d last=%b", k, $signed(cap_d[k]), cap_l[k], $signed(exp_d[k]), exp_l[k]);
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL impulse_busy: got %b want 0", busy); end
    checks++; if (frame_count !== 16'(exp_fc)) begin errors++; $display("FAIL impulse_frame_count: got %0d want %0d", frame_count, exp_fc); end
    @(posedge axi_clk); #1;
  endtask

  task automatic test_ramp();
    int len, stp;
    for (int t = 0; t < 3; t++) begin
      len = (t == 0) ? 5 : int'($urandom_range(1, 9));
      stp = (t == 0) ? 3 : int'($signed(16'($urandom)));
      do_start(1, len, 0, stp, 1'b0);
      collect(0, 2 * len - 1, t != 0, 200);
      build_expected(1, len, 0, stp, 2 * len);
      exp_fc += 2;
      checks++; if (timed_out || cap_d.size() != exp_d.size()) begin errors++; $display("FAIL ramp%0d_beats: got %0d timeout=%b want %0d", t, cap_d.size(), timed_out, exp_d.size()); end
      for (int k = 0; k < cap_d.size() && k < exp_d.size(); k++) begin
        checks++;
        if (cap_d[k] !== exp_d[k] || cap_l[k] !== exp_l[k]) begin
          errors++;
          $display("FAIL ramp%0d_beat%0d: got data=%0d last=%b want data=%0d last=%b", t, k, $signed(cap_d[k]), cap_l[k], $signed(exp_d[k]), exp_l[k]);
        end
      end
      checks++; if (frame_count !== 16'(exp_fc)) begin errors++; $display("FAIL ramp%0d_frame_count: got %0d want %0d", t, frame_count, exp_fc); end
      @(posedge axi_clk); #1;
    end
  endtask

  task automatic test_square();
    int amps[4] = '{-32768, 7, 5, 0};
    int lens[4] = '{3, 4, 0, 0};
    int len_eff;
    amps[3] = int'($signed(16'($urandom)));
    lens[3] = int'($urandom_range(1, 11));
    for (int t = 0; t < 4; t++) begin
      len_eff = (lens[t] == 0) ? 1 : lens[t];
      do_start(2, lens[t], amps[t], 0, 1'b0);
      collect(2, len_eff - 1, 1'b0, 200);
      build_expected(2, lens[t], amps[t], 0, len_eff);
      exp_fc += 1;
      checks++; if (timed_out || cap_d.size() != exp_d.size()) begin errors++; $display("FAIL square%0d_beats: got %0d timeout=%b want %0d", t, cap_d.size(), timed_out, exp_d.size()); end
      for (int k = 0; k < cap_d.size() && k < exp_d.size(); k++) begin
        checks++;
        if (cap_d[k] !== exp_d[k] || cap_l[k] !== exp_l[k]) begin
          errors++;
          $display("FAIL square%0d_beat%0d: got data=%0d last=%b want data=%0d last=%b", t, k, $signed(cap_d[k]), cap_l[k], $signed(exp_d[k]), exp_l[k]);
        end
      end
      @(posedge axi_clk); #1;
    end
    checks++; if (frame_count !== 16'(exp_fc)) begin errors++; $display("FAIL square_frame_count: got %0d want %0d", frame_count, exp_fc); end
  endtask

  task automatic test_backpressure();
    int len, stp;
    for (int t = 0; t < 2; t++) begin
      len = (t == 0) ? 6 : 7;
      stp = (t == 0) ? 1 : int'($signed(16'($urandom)));
      do_start(1, len, 0, stp, 1'b0);
      collect(t + 1, 2 * len - 1, 1'b1, 300);
      build_expected(1, len, 0, stp, 2 * len);
      exp_fc += 2;
      checks++; if (stall_changes != 0) begin errors++; $display("FAIL backpressure%0d_stall: got %0d changes while stalled want 0", t, stall_changes); end
      checks++; if (timed_out || cap_d.size() != exp_d.size()) begin errors++; $display("FAIL backpressure%0d_beats: got %0d timeout=%b want %0d", t, cap_d.size(), timed_out, exp_d.size()); end
      for (int k = 0; k < cap_d.size() && k < exp_d.size(); k++) begin
        checks++;
        if (cap_d[k] !== exp_d[k] || cap_l[k] !== exp_l[k]) begin
          errors++;
          $display("FAIL backpressure%0d_beat%0d: got data=%0d last=%b want data=%0d last=%b", t, k, $signed(cap_d[k]), cap_l[k], $signed(exp_d[k]), exp_l[k]);
        end
      end
      @(posedge axi_clk); #1;
    end
  endtask

  task automatic test_stop();
    int lens[2] = '{8, 3};
    int stops[2] = '{1, 2};
    for (int t = 0; t < 2; t++) begin
      do_start(1, lens[t], 0, 1, 1'b0);
      collect(0, stops[t], 1'b0, 100);
      build_expected(1, lens[t], 0, 1, lens[t]);
      exp_fc += 1;
      checks++; if (timed_out || cap_d.size() != exp_d.size()) begin errors++; $display("FAIL stop%0d_beats: got %0d timeout=%b want %0d", t, cap_d.size(), timed_out, exp_d.size()); end
      for (int k = 0; k < cap_d.size() && k < exp_d.size(); k++) begin
        checks++;
        if (cap_d[k] !== exp_d[k] || cap_l[k] !== exp_l[k]) begin
          errors++;
          $display("FAIL stop%0d_beat%0d: got data=%0d last=%b want data=%0d last=%b", t, k, $signed(cap_d[k]), cap_l[k], $signed(exp_d[k]), exp_l[k]);
        end
      end
      checks++; if (busy !== 1'b0 || m_axis_valid !== 1'b0) begin errors++; $display("FAIL stop%0d_idle: got busy=%b valid=%b want 0 0", t, busy, m_axis_valid); end
      @(posedge axi_clk); #1;
    end
    checks++; if (frame_count !== 16'(exp_fc)) begin errors++; $display("FAIL stop_frame_count: got %0d want %0d", frame_count, exp_fc); end
  endtask

  task automatic test_idle_controls();
    stop = 1'b1;
    @(posedge axi_clk); #1;
    stop = 1'b0;
    @(negedge axi_clk);
    checks++; if (busy !== 1'b0 || m_axis_valid !== 1'b0) begin errors++; $display("FAIL idle_stop: got busy=%b valid=%b want 0 0", busy, m_axis_valid); end
    @(posedge axi_clk); #1;
    do_start(1, 3, 0, 2, 1'b1);
    collect(0, 5, 1'b0, 100);
    build_expected(1, 3, 0, 2, 6);
    exp_fc += 2;
    checks++; if (timed_out || cap_d.size() != exp_d.size()) begin errors++; $display("FAIL start_stop_beats: got %0d timeout=%b want %0d", cap_d.size(), timed_out, exp_d.size()); end
    for (int k = 0; k < cap_d.size() && k < exp_d.size(); k++) begin
      checks++;
      if (cap_d[k] !== exp_d[k] || cap_l[k] !== exp_l[k]) begin
        errors++;
        $display("FAIL start_stop_beat%0d: got data=%0d last=%b want data=%0d last=%b", k, $signed(cap_d[k]), cap_l[k], $signed(exp_d[k]), exp_l[k]);
      end
    end
    @(posedge axi_clk); #1;
  endtask

  task automatic test_noise();
    do_start(3, 5, 0, 0, 1'b0);
    collect(2, 9, 1'b0, 300);
    build_expected(3, 5, 0, 0, 10);
    exp_fc += 2;
    checks++; if (timed_out || cap_d.size() != exp_d.size()) begin errors++; $display("FAIL noise_beats: got %0d timeout=%b want %0d", cap_d.size(), timed_out, exp_d.size()); end
    for (int k = 0; k < cap_d.size() && k < exp_d.size(); k++) begin
      checks++;
      if (cap_d[k] !== exp_d[k] || cap_l[k] !== exp_l[k]) begin
        errors++;
        $display("FAIL noise_beat%0d: got data=%h last=%b want data=%h last=%b", k, cap_d[k], cap_l[k], exp_d[k], exp_l[k]);
      end
    end
    checks++; if (frame_count !== 16'(exp_fc)) begin errors++; $display("FAIL noise_frame_count: got %0d want %0d", frame_count, exp_fc); end
    @(posedge axi_clk); #1;
  endtask

  task automatic test_reset_mid();
    do_start(1, 8, 0, 1, 1'b0);
    m_axis_ready = 1'b1;
    repeat (3) @(posedge axi_clk);
    #3;
    checks++; if (m_axis_valid !== 1'b1 || frame_count !== 16'(exp_fc)) begin errors++; $display("FAIL midreset_before: got valid=%b frame_count=%0d want 1 %0d", m_axis_valid, frame_count, exp_fc); end
    axi_reset_n = 1'b0;
    #1;
    exp_fc = 0;
    checks++; if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", m_axis_valid); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL midreset_frame_count: got %0d want 0", frame_count); end
    checks++; if (busy !== 1'b0 || m_axis_last !== 1'b0 || m_axis_data !== '0) begin errors++; $display("FAIL midreset_outputs: got busy=%b last=%b data=%0d want 0 0 0", busy, m_axis_last, m_axis_data); end
    @(negedge axi_clk);
    axi_reset_n = 1'b1;
    @(posedge axi_clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge axi_clk);
    #1;
    axi_reset_n = 1'b1;
    @(posedge axi_clk); #1;
    test_reset();
    test_impulse();
    test_ramp();
    test_square();
    test_backpressure();
    test_stop();
    test_idle_controls();
    test_noise();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
